// File: rtl/decoder3to8_pulser_pkg.sv
// Shared types and helpers for the timed 3-to-8 line decoder.
package decoder3to8_pulser_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} dec_state_t;

  localparam logic [7:0] Y_IDLE = 8'hFF;

  function automatic logic [7:0] onehot_n(logic [2:0] c);
    return ~(8'b1 << c);
  endfunction

endpackage

// File: rtl/decoder3to8_pulser_if.sv
// Code-in handshake and decoded-line outputs of the pulser.
interface decoder3to8_pulser_if;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready;
  logic [7:0] y_n;
  logic [2:0] code_out;
  logic       busy;
  logic       done;

  modport master (
    output in_valid, in_code,
    input  in_ready, y_n, code_out, busy, done
  );

  modport slave (
    input  in_valid, in_code,
    output in_ready, y_n, code_out, busy, done
  );
endinterface

// File: rtl/decoder3to8_pulser_pulse_counter.sv
// Loadable down-counter shared by the pulse and gap phases; stops at zero.
module decoder3to8_pulser_pulse_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/decoder3to8_pulser.sv
// Registered 3-to-8 decoder: drives one active-low line for PULSE_LEN cycles,
// then idles GAP_LEN cycles before accepting the next code.
module decoder3to8_pulser
  import decoder3to8_pulser_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned GAP_LEN   = 1,
  parameter int unsigned CNT_W     = 8
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 en,
  decoder3to8_pulser_if.slave bus
);

  localparam bit               HAS_GAP    = (GAP_LEN > 0);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = HAS_GAP ? CNT_W'(GAP_LEN - 1) : '0;

  dec_state_t state_q;
  logic [7:0] y_n_q;
  logic [2:0] code_q;
  logic       busy_q;
  logic       done_q;

  logic             accept;
  logic             drive_end;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;

  assign bus.in_ready = (state_q == IDLE) & en & ~rst;
  assign accept       = bus.in_valid & bus.in_ready;
  assign drive_end    = en & (state_q == DRIVE) & cnt_zero;
  // Accept and end-of-drive are mutually exclusive, so one counter serves both phases.
  assign cnt_load     = accept | (drive_end & HAS_GAP);
  assign cnt_val      = accept ? PULSE_LOAD : GAP_LOAD;
  assign cnt_dec      = en & (state_q != IDLE);

  decoder3to8_pulser_pulse_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_n_q   <= Y_IDLE;
      code_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!en) begin
        // Abort: release the line without signalling completion.
        state_q <= IDLE;
        y_n_q   <= Y_IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (accept) begin
              code_q  <= bus.in_code;
              y_n_q   <= onehot_n(bus.in_code);
              busy_q  <= 1'b1;
              state_q <= DRIVE;
            end
          end
          DRIVE: begin
            if (cnt_zero) begin
              y_n_q  <= Y_IDLE;
              done_q <= 1'b1;
              if (HAS_GAP) begin
                state_q <= GAP;
              end else begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end
          end
          GAP: begin
            if (cnt_zero) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.y_n      = y_n_q;
  assign bus.code_out = code_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_decoder3to8_pulser.sv
// Random stimulus against two configurations (4/1 and 1/0), scoreboarded per cycle.
module tb_decoder3to8_pulser;

  typedef struct packed {
    logic [7:0] y_n;
    logic [2:0] code;
    logic       busy;
    logic       done;
    logic       ready;
  } exp_t;

  localparam int NCYC = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic [2:0] in_code;

  int checks = 0;
  int errors = 0;

  decoder3to8_pulser_if if0 ();
  decoder3to8_pulser_if if1 ();

  assign if0.in_valid = in_valid;
  assign if0.in_code  = in_code;
  assign if1.in_valid = in_valid;
  assign if1.in_code  = in_code;

  decoder3to8_pulser #(
    .PULSE_LEN (4),
    .GAP_LEN   (1),
    .CNT_W     (8)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (if0)
  );

  decoder3to8_pulser #(
    .PULSE_LEN (1),
    .GAP_LEN   (0),
    .CNT_W     (8)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (if1)
  );

  always #5 clk = ~clk;

  // Reference model: a pulse is described by its accept edge; phase = edges since accept.
  int         pl [2] = '{4, 1};
  int         gl [2] = '{1, 0};
  int         acc_t [2];
  bit         acc_v [2];
  logic [2:0] cm [2];

  exp_t q0 [$];
  exp_t q1 [$];

  function automatic bit busy_at(int i, int t);
    return acc_v[i] && ((t - acc_t[i]) < (pl[i] + gl[i]));
  endfunction

  function automatic exp_t expect_after(int i, int t, logic rst_n1, logic en_n1);
    exp_t       e;
    logic [7:0] one;
    int         ph;
    bit         drv;
    bit         gp;
    one    = 8'b1;
    ph     = t - acc_t[i];
    drv    = acc_v[i] && (ph < pl[i]);
    gp     = acc_v[i] && (ph >= pl[i]) && (ph < pl[i] + gl[i]);
    e.y_n  = drv ? ~(one << cm[i]) : 8'hFF;
    e.code = cm[i];
    e.busy = drv || gp;
    e.done = acc_v[i] && (ph == pl[i]);
    e.ready = !(drv || gp) && en_n1 && !rst_n1;
    return e;
  endfunction

  task automatic check(input string name, input int inst, input logic [7:0] act,
                       input logic [7:0] exp, input int t);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", name, inst, t, act, exp);
    end
  endtask

  task automatic compare(input int inst, input exp_t e, input logic [7:0] y,
                         input logic [2:0] c, input logic b, input logic d, input logic r);
    check("y_n", inst, y, e.y_n, $time);
    check("code_out", inst, {5'b0, c}, {5'b0, e.code}, $time);
    check("busy", inst, {7'b0, b}, {7'b0, e.busy}, $time);
    check("done", inst, {7'b0, d}, {7'b0, e.done}, $time);
    check("in_ready", inst, {7'b0, r}, {7'b0, e.ready}, $time);
  endtask

  // Monitor: every cycle the DUT presents registered outputs; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        compare(0, e, if0.y_n, if0.code_out, if0.busy, if0.done, if0.in_ready);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        compare(1, e, if1.y_n, if1.code_out, if1.busy, if1.done, if1.in_ready);
      end
    end
  end

  // Stimulus and model update.
  initial begin
    bit idle_prev;
    rst      = 1'b1;
    en       = 1'b1;
    in_valid = 1'b0;
    in_code  = 3'd0;
    for (int i = 0; i < 2; i++) begin
      acc_v[i] = 1'b0;
      acc_t[i] = 0;
      cm[i]    = 3'd0;
    end
    for (int t = 0; t < NCYC; t++) begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        idle_prev = (t == 0) ? 1'b1 : !busy_at(i, t - 1);
        if (rst) begin
          acc_v[i] = 1'b0;
          cm[i]    = 3'd0;
        end else if (!en) begin
          acc_v[i] = 1'b0;
        end else if (in_valid && idle_prev) begin
          acc_t[i] = t;
          acc_v[i] = 1'b1;
          cm[i]    = in_code;
        end
      end
      #1;
      if (t < 3) begin
        rst = 1'b1;
      end else begin
        rst = ($urandom_range(0, 59) == 0);
      end
      en       = ($urandom_range(0, 24) != 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_code  = 3'($urandom_range(0, 7));
      q0.push_back(expect_after(0, t, rst, en));
      q1.push_back(expect_after(1, t, rst, en));
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ((q0.size() != 0) || (q1.size() != 0)) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
